// File: rtl/reset_seq_if.sv
// Reset sequencer bus: clock-lock, button, request sources and cause clear in; staged resets and cause out.
// Latency: not applicable (signal bundle only); backpressure: none, all signals are level/pulse.
interface reset_seq_if #(
    parameter int NUM_SRC = 4
);
    logic                 clk_ok;
    logic                 btn_n;
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC-1:0]   src_en;
    logic                 cause_clr;
    logic                 rst_per;
    logic                 rst_cpu;
    logic [NUM_SRC+2:0]   rst_cause;

    modport master (
        output clk_ok, btn_n, src_req, src_en, cause_clr,
        input  rst_per, rst_cpu, rst_cause
    );

    modport slave (
        input  clk_ok, btn_n, src_req, src_en, cause_clr,
        output rst_per, rst_cpu, rst_cause
    );
endinterface

// File: rtl/reset_seq.sv
// reset_seq: holds peripheral/CPU resets for 2^HOLD_W cycles after the last trigger, then releases them STAGGER apart.
// Latency: resets assert on the trigger edge; no backpressure, requests are sampled every cycle.
module reset_seq #(
    parameter int NUM_SRC = 4,
    parameter int HOLD_W  = 24,
    parameter int STAGGER = 16,
    parameter int SYNC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    reset_seq_if.slave  bus
);
    typedef enum logic [1:0] {HOLD, STAG, RUN} state_t;

    localparam logic [7:0]        STAG_LAST = (STAGGER > 0) ? 8'(STAGGER - 1) : 8'd0;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [7:0]          stag_cnt;
    logic                arm;
    logic                per_q;
    logic                cpu_q;
    logic [NUM_SRC+2:0]  cause_q;
    logic [SYNC-1:0]     btn_sync;
    logic                btn_prev;
    logic                btn_trig;
    logic [NUM_SRC+2:0]  cause_new;
    logic                trig;
    logic                clr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync <= '1;
            btn_prev <= 1'b1;
        end else begin
            btn_sync <= {btn_sync[SYNC-2:0], bus.btn_n};
            btn_prev <= btn_sync[SYNC-1];
        end
    end

    always_comb begin
        btn_trig  = btn_prev & ~btn_sync[SYNC-1];
        cause_new = {bus.src_req & bus.src_en, ~bus.clk_ok, btn_trig, 1'b0};
        trig      = |cause_new;
        clr_ok    = bus.cause_clr && (state == RUN);
    end

    // arm makes the first edge after power-on reset behave like a trigger edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
            stag_cnt <= '0;
            arm      <= 1'b1;
            per_q    <= 1'b1;
            cpu_q    <= 1'b1;
            cause_q  <= {{(NUM_SRC+2){1'b0}}, 1'b1};
        end else begin
            if (trig)
                cause_q <= (clr_ok ? '0 : cause_q) | cause_new;
            else if (clr_ok)
                cause_q <= '0;

            if (trig) begin
                state    <= HOLD;
                hold_cnt <= '0;
                stag_cnt <= '0;
                arm      <= 1'b0;
                per_q    <= 1'b1;
                cpu_q    <= 1'b1;
            end else begin
                case (state)
                    HOLD: begin
                        if (arm) begin
                            arm <= 1'b0;
                        end else if (&hold_cnt) begin
                            per_q    <= 1'b0;
                            stag_cnt <= '0;
                            if (STAGGER == 0) begin
                                state <= RUN;
                                cpu_q <= 1'b0;
                            end else begin
                                state <= STAG;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                    end
                    STAG: begin
                        if (stag_cnt == STAG_LAST) begin
                            state <= RUN;
                            cpu_q <= 1'b0;
                        end else begin
                            stag_cnt <= stag_cnt + 8'd1;
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= HOLD;
                        per_q <= 1'b1;
                        cpu_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rst_per   = per_q;
    assign bus.rst_cpu   = cpu_q;
    assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq with HOLD_W=4, STAGGER=3, NUM_SRC=2, SYNC=2: vector table plus hand-written corner sequences.
// Expected release edges are queued when a trigger is driven and compared when the resets fall.
module tb_reset_seq;
    localparam int HOLD_CYC = 16;
    localparam int STAG_CYC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    reset_seq_if #(.NUM_SRC(2)) bus ();

    reset_seq #(
        .NUM_SRC (2),
        .HOLD_W  (4),
        .STAGGER (3),
        .SYNC    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         per_edge;
        int         cpu_edge;
        logic [4:0] cause;
    } exp_t;

    typedef struct {
        string      name;
        logic [1:0] req;
        logic [1:0] en;
        bit         clr;
        bit         clk_low;
        bit         btn_low;
        int         len;
        int         lat;
        bit         trig;
        logic [4:0] cause;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    int per_fall  = -1;
    int cpu_fall  = -1;
    int per_rises = 0;
    bit prev_per  = 1'b1;
    bit prev_cpu  = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (prev_per && !bus.rst_per) per_fall = cyc;
        if (!prev_per && bus.rst_per) per_rises++;
        if (prev_cpu && !bus.rst_cpu) cpu_fall = cyc;
        if (!bus.rst_cpu) check("order_per_under_cpu", bus.rst_per, 0);
        prev_per = bus.rst_per;
        prev_cpu = bus.rst_cpu;
    end

    task automatic push(input string nm, input int k, input logic [4:0] cause);
        sb.push_back('{nm, k + HOLD_CYC, k + HOLD_CYC + STAG_CYC, cause});
        per_fall = -1;
        cpu_fall = -1;
    endtask

    task automatic drain();
        exp_t e;
        int   n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            while (cpu_fall < 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (cpu_fall < 0) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: rst_cpu still %0b, want release by edge %0d", e.name, bus.rst_cpu, e.cpu_edge);
            end else begin
                check({e.name, "_per_edge"}, per_fall, e.per_edge);
                check({e.name, "_cpu_edge"}, cpu_fall, e.cpu_edge);
                check({e.name, "_cause"}, bus.rst_cause, e.cause);
            end
        end
    endtask

    task automatic idle();
        bus.src_req   = 2'b00;
        bus.src_en    = 2'b11;
        bus.cause_clr = 1'b0;
        bus.clk_ok    = 1'b1;
        bus.btn_n     = 1'b1;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({nm, "_per_async"}, bus.rst_per, 1);
        check({nm, "_cpu_async"}, bus.rst_cpu, 1);
        check({nm, "_cause_async"}, bus.rst_cause, 5'b00001);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(nm, cyc + 1, 5'b00001);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        int r0;

        vecs[0] = '{"clr_run",      2'b00, 2'b11, 1'b1, 1'b0, 1'b0,   1, 0, 1'b0, 5'b00000};
        vecs[1] = '{"masked_src",   2'b01, 2'b10, 1'b0, 1'b0, 1'b0,   1, 0, 1'b0, 5'b00000};
        vecs[2] = '{"btn_hold",     2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 100, 2, 1'b1, 5'b00010};
        vecs[3] = '{"clk_loss",     2'b00, 2'b11, 1'b0, 1'b1, 1'b0,   5, 4, 1'b1, 5'b00110};
        vecs[4] = '{"clr_and_src0", 2'b01, 2'b11, 1'b1, 1'b0, 1'b0,   1, 0, 1'b1, 5'b01000};
        vecs[5] = '{"src1",         2'b10, 2'b11, 1'b0, 1'b0, 1'b0,   1, 0, 1'b1, 5'b11000};
        vecs[6] = '{"clr_again",    2'b00, 2'b11, 1'b1, 1'b0, 1'b0,   1, 0, 1'b0, 5'b00000};

        idle();
        do_reset("power_on");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            r0 = per_rises;
            t0 = cyc + 1;
            bus.src_req   = vecs[i].req;
            bus.src_en    = vecs[i].en;
            bus.cause_clr = vecs[i].clr;
            bus.clk_ok    = ~vecs[i].clk_low;
            bus.btn_n     = ~vecs[i].btn_low;
            if (vecs[i].trig) push(vecs[i].name, t0 + vecs[i].lat, vecs[i].cause);
            repeat (vecs[i].len) @(negedge clk);
            idle();
            drain();
            repeat (25) @(negedge clk);
            check({vecs[i].name, "_rises"}, per_rises - r0, vecs[i].trig ? 1 : 0);
            check({vecs[i].name, "_per"}, bus.rst_per, 0);
            check({vecs[i].name, "_cpu"}, bus.rst_cpu, 0);
            check({vecs[i].name, "_cause"}, bus.rst_cause, vecs[i].cause);
        end

        // retrigger during the stagger window, then try to clear the cause while holding
        @(negedge clk);
        t0 = cyc + 1;
        bus.src_req = 2'b01;
        @(negedge clk);
        bus.src_req = 2'b00;
        repeat (HOLD_CYC) @(negedge clk);
        check("stag_per", bus.rst_per, 0);
        check("stag_cpu", bus.rst_cpu, 1);
        t1 = cyc + 1;
        check("stag_edge", t1, t0 + HOLD_CYC + 1);
        bus.src_req = 2'b10;
        push("stag_restart", t1, 5'b11000);
        @(negedge clk);
        bus.src_req = 2'b00;
        check("restart_per", bus.rst_per, 1);
        check("restart_cpu", bus.rst_cpu, 1);
        repeat (2) @(negedge clk);
        bus.cause_clr = 1'b1;
        @(negedge clk);
        bus.cause_clr = 1'b0;
        check("hold_clr_ignored", bus.rst_cause, 5'b11000);
        drain();

        do_reset("rst_mid_run");
        repeat (5) @(negedge clk);
        check("final_per", bus.rst_per, 0);
        check("final_cpu", bus.rst_cpu, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
